// File: rtl/mux_4x1_pkg.sv
// Shared constants, select-code enum and lane extraction helper for the
// 4-to-1 lane selector.
package mux_4x1_pkg;

   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   // Widest lane lane_of() can extract; instances must keep WIDTH <= MAX_W.
   localparam int MAX_W  = 1024;

   typedef enum logic [SEL_W-1:0] {
      SEL_L0 = 2'd0,
      SEL_L1 = 2'd1,
      SEL_L2 = 2'd2,
      SEL_L3 = 2'd3
   } sel_e;

   typedef logic [NUM_IN*MAX_W-1:0] lanes_t;
   typedef logic [MAX_W-1:0]        lane_t;

   // Returns lane k of a packed lane vector whose lanes are `width` bits wide.
   // Bits above `width` in the result are zero.
   function automatic lane_t lane_of(input lanes_t      i,
                                     input int unsigned width,
                                     input logic [SEL_W-1:0] k);
      lanes_t shifted;
      shifted = i >> (32'(k) * width);
      return lane_t'(shifted) & ~({MAX_W{1'b1}} << width);
   endfunction

endpackage : mux_4x1_pkg

// File: rtl/mux_sel_decode.sv
// 2-to-4 one-hot decoder for the lane select; exactly one output bit is set
// for every legal select code.
module mux_sel_decode
   import mux_4x1_pkg::*;
(
   input  logic [SEL_W-1:0]  s,
   output logic [NUM_IN-1:0] sel_oh
);

   always_comb begin
      // NOTE: assigning a default before the case guarantees every path
      // drives sel_oh, so no latch can be inferred.
      sel_oh = '0;
      case (sel_e'(s))
         SEL_L0:  sel_oh[0] = 1'b1;
         SEL_L1:  sel_oh[1] = 1'b1;
         SEL_L2:  sel_oh[2] = 1'b1;
         SEL_L3:  sel_oh[3] = 1'b1;
         default: sel_oh    = '0;
      endcase
   end

endmodule : mux_sel_decode

// File: rtl/mux_4x1.sv
// 4-to-1 lane selector: combinational output y, a registered copy y_q with
// capture enable, and the one-hot select decode.
module mux_4x1
   import mux_4x1_pkg::*;
#(
   parameter int          WIDTH     = 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] i,
   input  logic [SEL_W-1:0]        s,
   input  logic                    en,
   output logic [WIDTH-1:0]        y,
   output logic [WIDTH-1:0]        y_q,
   output logic                    q_valid,
   output logic [NUM_IN-1:0]       sel_oh
);

   logic [WIDTH-1:0] lane [NUM_IN];

   mux_sel_decode u_decode (
      .s      (s),
      .sel_oh (sel_oh)
   );

   for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
      assign lane[k] = WIDTH'(lane_of(lanes_t'(i), WIDTH, SEL_W'(k)));
   end

   // AND-OR mux: the one-hot gate lets at most one lane reach the OR tree.
   always_comb begin
      y = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         y = y | (lane[k] & {WIDTH{sel_oh[k]}});
      end
   end

   // Reset is sampled on the clock edge and overrides the capture enable.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make y_q and q_valid update together
      // from values sampled at the edge, independent of statement order.
      if (!rst_n) begin
         y_q     <= WIDTH'(RESET_VAL);
         q_valid <= 1'b0;
      end else if (en) begin
         y_q     <= y;
         q_valid <= 1'b1;
      end
   end

endmodule : mux_4x1

// File: tb/tb_mux_4x1.sv
// Directed bench for mux_4x1: a WIDTH=1 instance and a WIDTH=8 instance with a
// non-zero reset value that must be truncated to 8 bits.
module tb_mux_4x1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;

   logic [3:0] i1;
   logic [1:0] s1;
   logic       y1, y_q1, q_valid1;
   logic [3:0] sel_oh1;

   logic [31:0] i8;
   logic [1:0]  s8;
   logic [7:0]  y8, y_q8;
   logic        q_valid8;
   logic [3:0]  sel_oh8;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [7:0] RV8 = 8'h5A;

   always #5 clk = ~clk;

   mux_4x1 #(.WIDTH(1), .RESET_VAL(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .i(i1), .s(s1), .en(en),
      .y(y1), .y_q(y_q1), .q_valid(q_valid1), .sel_oh(sel_oh1)
   );

   mux_4x1 #(.WIDTH(8), .RESET_VAL(32'h15A)) dut8 (
      .clk(clk), .rst_n(rst_n), .i(i8), .s(s8), .en(en),
      .y(y8), .y_q(y_q8), .q_valid(q_valid8), .sel_oh(sel_oh8)
   );

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b1; i1 = 4'b0110; s1 = 2'd1;
      i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1}; s8 = 2'd2;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (y_q1 !== 1'b0) begin miscompares++; $display("FAIL reset_yq1 got %b want 0", y_q1); end
      vectors++; if (q_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_qv1 got %b want 0", q_valid1); end
      vectors++; if (y1 !== 1'b1) begin miscompares++; $display("FAIL reset_y1_tracks got %b want 1", y1); end
      vectors++; if (y_q8 !== RV8) begin miscompares++; $display("FAIL reset_yq8 got %h want %h", y_q8, RV8); end
      vectors++; if (q_valid8 !== 1'b0) begin miscompares++; $display("FAIL reset_qv8 got %b want 0", q_valid8); end
      vectors++; if (y8 !== 8'hC3) begin miscompares++; $display("FAIL reset_y8_tracks got %h want c3", y8); end
      s1 = 2'd0; #1;
      vectors++; if (y1 !== 1'b0) begin miscompares++; $display("FAIL reset_y1_tracks2 got %b want 0", y1); end
   endtask

   task automatic test_comb_basic();
      en = 1'b0;
      s1 = 2'b00; i1 = 4'b1010; #10;
      vectors++; if (y1 !== 1'b0) begin miscompares++; $display("FAIL comb_s0 y got %b want 0", y1); end
      vectors++; if (sel_oh1 !== 4'b0001) begin miscompares++; $display("FAIL comb_s0 sel_oh got %b want 0001", sel_oh1); end
      s1 = 2'b01; i1 = 4'b0101; #10;
      vectors++; if (y1 !== 1'b0) begin miscompares++; $display("FAIL comb_s1 y got %b want 0", y1); end
      vectors++; if (sel_oh1 !== 4'b0010) begin miscompares++; $display("FAIL comb_s1 sel_oh got %b want 0010", sel_oh1); end
      s1 = 2'b10; i1 = 4'b1100; #10;
      vectors++; if (y1 !== 1'b1) begin miscompares++; $display("FAIL comb_s2 y got %b want 1", y1); end
      s1 = 2'b11; i1 = 4'b0011; #10;
      vectors++; if (y1 !== 1'b0) begin miscompares++; $display("FAIL comb_s3 y got %b want 0", y1); end
      s1 = 2'b10; i1 = 4'b1111; #10;
      vectors++; if (y1 !== 1'b1) begin miscompares++; $display("FAIL comb_s2b y got %b want 1", y1); end
   endtask

   task automatic test_enable();
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; s1 = 2'b10; i1 = 4'b0100; s8 = 2'd0;
      @(posedge clk); #1;
      vectors++; if (y_q1 !== 1'b1) begin miscompares++; $display("FAIL en_capture yq got %b want 1", y_q1); end
      vectors++; if (q_valid1 !== 1'b1) begin miscompares++; $display("FAIL en_capture qv got %b want 1", q_valid1); end
      vectors++; if (y_q8 !== 8'hA1) begin miscompares++; $display("FAIL en_capture yq8 got %h want a1", y_q8); end
      @(negedge clk);
      en = 1'b0; i1 = 4'b0000; s8 = 2'd3; #1;
      vectors++; if (y1 !== 1'b0) begin miscompares++; $display("FAIL hold y got %b want 0", y1); end
      vectors++; if (y_q1 !== 1'b1) begin miscompares++; $display("FAIL hold yq_pre got %b want 1", y_q1); end
      @(posedge clk); #1;
      vectors++; if (y_q1 !== 1'b1) begin miscompares++; $display("FAIL hold yq got %b want 1", y_q1); end
      vectors++; if (q_valid1 !== 1'b1) begin miscompares++; $display("FAIL hold qv got %b want 1", q_valid1); end
      vectors++; if (y_q8 !== 8'hA1) begin miscompares++; $display("FAIL hold yq8 got %h want a1", y_q8); end
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b1; i1 = 4'b1111; s1 = 2'd3;
      @(posedge clk); #1;
      vectors++; if (y_q1 !== 1'b0) begin miscompares++; $display("FAIL rstpri yq1 got %b want 0", y_q1); end
      vectors++; if (q_valid1 !== 1'b0) begin miscompares++; $display("FAIL rstpri qv1 got %b want 0", q_valid1); end
      vectors++; if (y_q8 !== RV8) begin miscompares++; $display("FAIL rstpri yq8 got %h want %h", y_q8, RV8); end
      vectors++; if (q_valid8 !== 1'b0) begin miscompares++; $display("FAIL rstpri qv8 got %b want 0", q_valid8); end
      vectors++; if (y1 !== 1'b1) begin miscompares++; $display("FAIL rstpri y1 got %b want 1", y1); end
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] lanes [4];
      logic [7:0] prev;
      lanes[0] = 8'hA1; lanes[1] = 8'hB2; lanes[2] = 8'hC3; lanes[3] = 8'hD4;
      prev = RV8;
      i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         en = 1'b1; s8 = 2'(k); #1;
         vectors++; if (y8 !== lanes[k]) begin miscompares++; $display("FAIL w8_y lane %0d got %h want %h", k, y8, lanes[k]); end
         vectors++; if (y_q8 !== prev) begin miscompares++; $display("FAIL w8_lag lane %0d got %h want %h", k, y_q8, prev); end
         @(posedge clk); #1;
         prev = lanes[k];
         vectors++; if (y_q8 !== prev) begin miscompares++; $display("FAIL w8_cap lane %0d got %h want %h", k, y_q8, prev); end
         vectors++; if (q_valid8 !== 1'b1) begin miscompares++; $display("FAIL w8_qv lane %0d got %b want 1", k, q_valid8); end
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic test_exhaustive();
      logic [3:0] iv;
      logic [3:0] oh;
      en = 1'b0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 4; b++) begin
            iv = 4'(a);
            oh = 4'b0001 << b;
            i1 = iv; s1 = 2'(b); #1;
            vectors++; if (y1 !== iv[b]) begin miscompares++; $display("FAIL sweep_y i=%b s=%0d got %b want %b", iv, b, y1, iv[b]); end
            vectors++; if (sel_oh1 !== oh) begin miscompares++; $display("FAIL sweep_oh i=%b s=%0d got %b want %b", iv, b, sel_oh1, oh); end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; i1 = '0; s1 = '0; i8 = '0; s8 = '0;
      test_reset();
      test_comb_basic();
      test_enable();
      test_reset_priority();
      test_back_to_back();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mux_4x1
